// File: rtl/alu_src_mux_pkg.sv
// Shared datapath definitions: operand width and the ALUSrc select encoding
// that both the control unit and the operand mux agree on.
package alu_src_mux_pkg;

  localparam int XLEN = 32;

  // ALUSrc encoding driven by the control unit.
  typedef enum logic {
    ALUSRC_REG = 1'b0,
    ALUSRC_IMM = 1'b1
  } alusrc_e;

  // Operand chosen for a given ALUSrc value; used by anything that models the mux.
  function automatic logic [XLEN-1:0] alusrc_pick(input logic             sel,
                                                  input logic [XLEN-1:0] reg_data2,
                                                  input logic [XLEN-1:0] imm_ext);
    return (sel == ALUSRC_IMM) ? imm_ext : reg_data2;
  endfunction

endpackage

// File: rtl/alu_src_mux_if.sv
// Operand-select bus between the decode side (register file, immediate generator,
// control) and the ALU operand-B mux, including its registered debug taps.
interface alu_src_mux_if
  import alu_src_mux_pkg::*;
#(
  parameter int WIDTH = XLEN
);

  logic [WIDTH-1:0] reg_data2;
  logic [WIDTH-1:0] imm_ext;
  logic             sel;
  logic [WIDTH-1:0] alu_in2;
  logic [WIDTH-1:0] alu_in2_q;
  logic             sel_q;

  // Decode side: supplies candidates and the select, observes the result and taps.
  modport master (
    output reg_data2,
    output imm_ext,
    output sel,
    input  alu_in2,
    input  alu_in2_q,
    input  sel_q
  );

  // Mux side.
  modport slave (
    input  reg_data2,
    input  imm_ext,
    input  sel,
    output alu_in2,
    output alu_in2_q,
    output sel_q
  );

endinterface

// File: rtl/alu_src_mux_mux2.sv
// Generic WIDTH-bit 2:1 mux, shared by the ALU operand, PC and writeback selects.
module mux2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o
);

  // A ternary keeps an unknown select propagating as X rather than latching.
  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/alu_src_mux.sv
// ALU operand-B select for the single-cycle datapath: zero-latency mux of rs2 data
// vs. immediate, plus optional registered copies of the operand and select.
module alu_src_mux
  import alu_src_mux_pkg::*;
#(
  parameter int WIDTH   = XLEN,
  parameter bit REG_TAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_src_mux_if.slave bus
);

  logic [WIDTH-1:0] alu_in2_w;

  mux2 #(.WIDTH(WIDTH)) u_mux2 (
    .d0_i  (bus.reg_data2),
    .d1_i  (bus.imm_ext),
    .sel_i (bus.sel),
    .y_o   (alu_in2_w)
  );

  // The operand path never sees clk or rst_n so single-cycle timing is untouched.
  assign bus.alu_in2 = alu_in2_w;

  if (REG_TAP) begin : g_tap
    logic [WIDTH-1:0] alu_in2_d;
    logic [WIDTH-1:0] alu_in2_q;
    logic             sel_d;
    logic             sel_q;

    assign alu_in2_d = alu_in2_w;
    assign sel_d     = bus.sel;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        alu_in2_q <= '0;
        sel_q     <= ALUSRC_REG;
      end else begin
        alu_in2_q <= alu_in2_d;
        sel_q     <= sel_d;
      end
    end

    assign bus.alu_in2_q = alu_in2_q;
    assign bus.sel_q     = sel_q;
  end else begin : g_no_tap
    assign bus.alu_in2_q = '0;
    assign bus.sel_q     = 1'b0;
  end

`ifndef SYNTHESIS
  // An undriven ALUSrc out of reset usually means a decode hole in the control unit.
  always @(posedge clk) begin
    if (rst_n && $isunknown(bus.sel))
      $warning("alu_src_mux: ALUSrc select is unknown while out of reset");
  end
`endif

endmodule

// File: tb/tb_alu_src_mux.sv
// Self-checking bench for alu_src_mux: directed select/boundary/reset/tap scenarios
// followed by randomized vectors against a behavioural operand/tap model.
module tb_alu_src_mux;
  import alu_src_mux_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  alu_src_mux_if #(.WIDTH(W)) bus ();

  alu_src_mux #(.WIDTH(W), .REG_TAP(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the operand: plain rule from the datapath description.
  function automatic logic [W-1:0] model_op(input logic s, input logic [W-1:0] r,
                                            input logic [W-1:0] i);
    if (s) return i;
    return r;
  endfunction

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.reg_data2 = 32'd0;
    bus.imm_ext   = 32'd0;
    bus.sel       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.alu_in2_q !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_alu_in2_q: got %h expected %h", bus.alu_in2_q, 32'd0);
    end
    n_cmp++;
    if (bus.sel_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sel_q: got %b expected %b", bus.sel_q, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_select();
    @(negedge clk);
    bus.reg_data2 = 32'd15;
    bus.imm_ext   = 32'd99;
    bus.sel       = ALUSRC_REG;
    #1;
    n_cmp++;
    if (bus.alu_in2 !== 32'd15) begin
      n_fail++;
      $display("FAIL select_reg: got %0d expected %0d", bus.alu_in2, 15);
    end
    bus.sel = ALUSRC_IMM;
    #1;
    n_cmp++;
    if (bus.alu_in2 !== 32'd99) begin
      n_fail++;
      $display("FAIL select_imm: got %0d expected %0d", bus.alu_in2, 99);
    end
    bus.sel = ALUSRC_REG;
    #1;
    n_cmp++;
    if (bus.alu_in2 !== 32'd15) begin
      n_fail++;
      $display("FAIL select_back_reg: got %0d expected %0d", bus.alu_in2, 15);
    end
    // Select and data changing together: output follows the final values.
    bus.sel       = ALUSRC_IMM;
    bus.imm_ext   = 32'd1234;
    bus.reg_data2 = 32'd4321;
    #1;
    n_cmp++;
    if (bus.alu_in2 !== 32'd1234) begin
      n_fail++;
      $display("FAIL select_same_step: got %0d expected %0d", bus.alu_in2, 1234);
    end
  endtask

  task automatic test_boundaries();
    @(negedge clk);
    bus.reg_data2 = 32'hFFFF_FFFF;
    bus.imm_ext   = 32'h8000_0000;
    bus.sel       = ALUSRC_REG;
    #1;
    n_cmp++;
    if (bus.alu_in2 !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL boundary_reg: got %h expected %h", bus.alu_in2, 32'hFFFF_FFFF);
    end
    bus.sel = ALUSRC_IMM;
    #1;
    n_cmp++;
    if (bus.alu_in2 !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL boundary_imm: got %h expected %h", bus.alu_in2, 32'h8000_0000);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.alu_in2_q !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL boundary_tap: got %h expected %h", bus.alu_in2_q, 32'h8000_0000);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.sel       = ALUSRC_IMM;
    bus.imm_ext   = 32'hA5A5_0001;
    bus.reg_data2 = 32'h0000_0022;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.alu_in2_q !== 32'hA5A5_0001 || bus.sel_q !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_preload: got %h/%b expected %h/%b", bus.alu_in2_q, bus.sel_q,
               32'hA5A5_0001, 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.alu_in2_q !== 32'd0 || bus.sel_q !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: got %h/%b expected 0/0", bus.alu_in2_q, bus.sel_q);
    end
    n_cmp++;
    if (bus.alu_in2 !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL areset_comb_imm: got %h expected %h", bus.alu_in2, 32'hA5A5_0001);
    end
    bus.sel = ALUSRC_REG;
    #1;
    n_cmp++;
    if (bus.alu_in2 !== 32'h0000_0022) begin
      n_fail++;
      $display("FAIL areset_comb_reg: got %h expected %h", bus.alu_in2, 32'h0000_0022);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.alu_in2_q !== 32'd0 || bus.sel_q !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_held: got %h/%b expected 0/0", bus.alu_in2_q, bus.sel_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_tap_capture();
    bus.sel     = ALUSRC_IMM;
    bus.imm_ext = 32'd7;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.alu_in2_q !== 32'd7 || bus.sel_q !== 1'b1) begin
      n_fail++;
      $display("FAIL tap_first_capture: got %0d/%b expected 7/1", bus.alu_in2_q, bus.sel_q);
    end
    bus.imm_ext = 32'd8;
    #1;
    n_cmp++;
    if (bus.alu_in2 !== 32'd8) begin
      n_fail++;
      $display("FAIL tap_comb_update: got %0d expected 8", bus.alu_in2);
    end
    n_cmp++;
    if (bus.alu_in2_q !== 32'd7) begin
      n_fail++;
      $display("FAIL tap_hold: got %0d expected 7", bus.alu_in2_q);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] r;
    logic [W-1:0] i;
    logic         s;
    logic [W-1:0] exp_q;
    logic         exp_sel_q;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      r = $urandom;
      i = $urandom;
      s = 1'($urandom_range(0, 1));
      bus.reg_data2 = r;
      bus.imm_ext   = i;
      bus.sel       = s;
      #1;
      n_cmp++;
      if (bus.alu_in2 !== model_op(s, r, i)) begin
        n_fail++;
        $display("FAIL rand_comb[%0d]: got %h expected %h", n, bus.alu_in2, model_op(s, r, i));
      end
      exp_q     = model_op(s, r, i);
      exp_sel_q = s;
      if (n % 8 == 0) begin
        // Glitch an input mid-phase; only the value present at the edge is captured.
        bus.reg_data2 = ~r;
        #1;
        bus.reg_data2 = r;
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.alu_in2_q !== exp_q || bus.sel_q !== exp_sel_q) begin
        n_fail++;
        $display("FAIL rand_tap[%0d]: got %h/%b expected %h/%b", n, bus.alu_in2_q, bus.sel_q,
                 exp_q, exp_sel_q);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_select();
    test_boundaries();
    test_async_reset();
    test_tap_capture();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
